// File: rtl/half_duplex_bus_port.sv
// half_duplex_bus_port: one end of a shared tri-stated half-duplex bus. It
// arbitrates for the bus, drives bursts of up to MAX_BURST words framed by
// TURN released cycles, captures peer words and flags drive collisions.
// Latency: a tx word reaches the bus TURN+1 cycles after tx_valid in IDLE
// (the next cycle when TURN=0). rx_data/rx_valid and collision are registered
// one cycle after the sampled event.
// Backpressure: tx_ready is high only while driving and the peer is quiet.
// The peer always wins arbitration.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   bus                shared bus; driven only while dir_out=1, else high-Z
//   dir_out            buffer direction control, 1 = this port drives
//   peer_drive         peer is currently driving the bus
//   tx_data/tx_valid/tx_ready   local transmit stream (valid/ready)
//   rx_data/rx_valid   last captured peer word, with a one-cycle update pulse
//   collision          one-cycle pulse on a detected drive conflict
module half_duplex_bus_port #(
  parameter int WIDTH     = 8,
  parameter int TURN      = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] bus,
  output logic             dir_out,
  input  logic             peer_drive,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             collision
);

  // The turn counter must hold TURN. It keeps one bit even when TURN=0.
  localparam int CW = (TURN < 1) ? 1 : $clog2(TURN + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TURN_TX = 2'd1,
    DRIVE   = 2'd2,
    TURN_RX = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    turn_cnt, turn_nxt;
  logic [BW-1:0]    burst_cnt, burst_nxt;
  logic [WIDTH-1:0] rx_data_nxt;
  logic             rx_valid_nxt;
  logic             collision_nxt;

  assign dir_out = (state == DRIVE);
  // Gating with rst keeps a word that is in flight when reset lands from
  // being counted as accepted.
  assign tx_ready = (state == DRIVE) & ~peer_drive & ~rst;
  assign bus      = dir_out ? tx_data : {WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      turn_cnt  <= '0;
      burst_cnt <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      collision <= 1'b0;
    end else begin
      state     <= state_nxt;
      turn_cnt  <= turn_nxt;
      burst_cnt <= burst_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      collision <= collision_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    turn_nxt      = turn_cnt;
    burst_nxt     = burst_cnt;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    collision_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (peer_drive) begin
          rx_data_nxt  = bus;
          rx_valid_nxt = 1'b1;
        end else if (tx_valid) begin
          if (TURN == 0) begin
            state_nxt = DRIVE;
            burst_nxt = '0;
          end else begin
            state_nxt = TURN_TX;
            turn_nxt  = CW'(TURN);
          end
        end
      end

      TURN_TX: begin
        if (peer_drive) begin
          collision_nxt = 1'b1;
          state_nxt     = IDLE;
          turn_nxt      = '0;
        end else if (turn_cnt <= CW'(1)) begin
          // The last released cycle: start driving on the next edge.
          state_nxt = DRIVE;
          turn_nxt  = '0;
          burst_nxt = '0;
        end else begin
          turn_nxt = turn_cnt - CW'(1);
        end
      end

      DRIVE: begin
        if (peer_drive) begin
          collision_nxt = 1'b1;
          state_nxt     = TURN_RX;
          turn_nxt      = CW'(TURN);
        end else if (!tx_valid) begin
          state_nxt = TURN_RX;
          turn_nxt  = CW'(TURN);
        end else begin
          burst_nxt = burst_cnt + BW'(1);
          if (burst_cnt + BW'(1) == BW'(MAX_BURST)) begin
            state_nxt = TURN_RX;
            turn_nxt  = CW'(TURN);
          end
        end
      end

      TURN_RX: begin
        // peer_drive is deliberately ignored while releasing the bus.
        // TURN=0 loads 0, so this state still lasts one cycle.
        if (turn_cnt <= CW'(1)) begin
          state_nxt = IDLE;
          turn_nxt  = '0;
        end else begin
          turn_nxt = turn_cnt - CW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_half_duplex_bus_port.sv
module tb_half_duplex_bus_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: TURN=2, MAX_BURST=4
  logic       a_tx_valid, a_peer, a_dir, a_ready, a_rxv, a_col;
  logic [7:0] a_tx_data, a_peer_dat, a_rxd;
  wire  [7:0] a_bus;
  assign a_bus = a_peer ? a_peer_dat : 8'bz;

  // Instance B: TURN=0, MAX_BURST=4
  logic       b_tx_valid, b_peer, b_dir, b_ready, b_rxv, b_col;
  logic [7:0] b_tx_data, b_peer_dat, b_rxd;
  wire  [7:0] b_bus;
  assign b_bus = b_peer ? b_peer_dat : 8'bz;

  half_duplex_bus_port #(.WIDTH(8), .TURN(2), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .bus(a_bus), .dir_out(a_dir), .peer_drive(a_peer),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_ready),
    .rx_data(a_rxd), .rx_valid(a_rxv), .collision(a_col)
  );

  half_duplex_bus_port #(.WIDTH(8), .TURN(0), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst(rst), .bus(b_bus), .dir_out(b_dir), .peer_drive(b_peer),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_ready),
    .rx_data(b_rxd), .rx_valid(b_rxv), .collision(b_col)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues: expected words on the bus at each accepted transfer,
  // expected captured words, and expected collision pulses.
  logic [7:0] a_txq[$], a_rxq[$], b_txq[$], b_rxq[$];
  int         a_colq[$], b_colq[$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [7:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%h expected=no event", nm, act);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents an output event.
  always @(negedge clk) begin
    if (a_tx_valid && a_ready) begin
      if (a_txq.size() == 0) unexpected("a_tx_unexpected", a_bus);
      else chk8("a_tx_bus", a_bus, a_txq.pop_front());
    end
    if (a_rxv) begin
      if (a_rxq.size() == 0) unexpected("a_rx_unexpected", a_rxd);
      else chk8("a_rx_data", a_rxd, a_rxq.pop_front());
    end
    if (a_col) begin
      if (a_colq.size() == 0) unexpected("a_col_unexpected", 8'h01);
      else begin
        checks++;
        void'(a_colq.pop_front());
      end
    end
    if (b_tx_valid && b_ready) begin
      if (b_txq.size() == 0) unexpected("b_tx_unexpected", b_bus);
      else chk8("b_tx_bus", b_bus, b_txq.pop_front());
    end
    if (b_rxv) begin
      if (b_rxq.size() == 0) unexpected("b_rx_unexpected", b_rxd);
      else chk8("b_rx_data", b_rxd, b_rxq.pop_front());
    end
    if (b_col) begin
      if (b_colq.size() == 0) unexpected("b_col_unexpected", 8'h01);
      else begin
        checks++;
        void'(b_colq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] hs_pat, dir_pat;
  logic [7:0]  d;

  initial begin
    rst = 1'b1;
    a_tx_valid = 1'b0; a_tx_data = 8'h00; a_peer = 1'b0; a_peer_dat = 8'h00;
    b_tx_valid = 1'b0; b_tx_data = 8'h00; b_peer = 1'b0; b_peer_dat = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk1("rst_a_dir", a_dir, 1'b0);
    chk1("rst_a_rxv", a_rxv, 1'b0);
    chk1("rst_a_col", a_col, 1'b0);
    chk8("rst_a_rxd", a_rxd, 8'h00);
    chk1("rst_a_ready", a_ready, 1'b0);
    chk1("rst_b_dir", b_dir, 1'b0);

    // Single word A5: two released turnaround cycles, then drive.
    a_tx_valid = 1'b1; a_tx_data = 8'hA5; a_txq.push_back(8'hA5);
    #1 chk1("t1_idle_dir", a_dir, 1'b0);
    tick(); chk1("t1_turn1_dir", a_dir, 1'b0);
    tick(); chk1("t1_turn2_dir", a_dir, 1'b0);
    tick();
    chk1("t1_drive_dir", a_dir, 1'b1);
    chk1("t1_drive_ready", a_ready, 1'b1);
    chk8("t1_drive_bus", a_bus, 8'hA5);
    tick(); a_tx_valid = 1'b0;
    #1 chk1("t1_drive_empty_dir", a_dir, 1'b1);
    // Peer drives during TURN_RX: must be ignored.
    tick(); chk1("t1_rx1_dir", a_dir, 1'b0);
    a_peer = 1'b1; a_peer_dat = 8'h77;
    tick(); chk1("t1_rx2_dir", a_dir, 1'b0);
    tick(); a_peer = 1'b0;
    chk1("t1_idle_dir2", a_dir, 1'b0);
    chk1("turnrx_no_capture", a_rxv, 1'b0);
    chk1("turnrx_no_col", a_col, 1'b0);

    // Receive 3C in IDLE.
    a_peer = 1'b1; a_peer_dat = 8'h3C; a_rxq.push_back(8'h3C);
    tick(); a_peer = 1'b0;
    chk1("rx_pulse", a_rxv, 1'b1);
    chk8("rx_data", a_rxd, 8'h3C);
    tick(); chk1("rx_pulse_end", a_rxv, 1'b0);

    // Burst cap: 01..06 offered back-to-back.
    hs_pat = '0; dir_pat = '0; d = 8'h01;
    for (int k = 1; k <= 6; k++) a_txq.push_back(8'(k));
    for (int i = 0; i < 15; i++) begin
      a_tx_valid = (d <= 8'h06);
      a_tx_data  = d;
      #1;
      hs_pat[i]  = a_tx_valid & a_ready;
      dir_pat[i] = a_dir;
      tick();
      if (hs_pat[i]) d = d + 8'h01;
    end
    chk16("burst_accept_cycles", hs_pat, 16'h3078);
    chk16("burst_dir_cycles", dir_pat, 16'h7078);
    tick(); tick();
    chk1("burst_end_dir", a_dir, 1'b0);

    // Collision in the second TURN_TX cycle.
    a_tx_valid = 1'b1; a_tx_data = 8'h99;
    tick(); chk1("ct_turn1_dir", a_dir, 1'b0);
    tick(); chk1("ct_turn2_dir", a_dir, 1'b0);
    a_peer = 1'b1; a_peer_dat = 8'h5A; a_colq.push_back(1);
    tick();
    chk1("ct_idle_dir", a_dir, 1'b0);
    chk1("ct_col_pulse", a_col, 1'b1);
    a_tx_valid = 1'b0; a_rxq.push_back(8'h5A);
    tick(); a_peer = 1'b0;
    chk1("ct_col_end", a_col, 1'b0);
    chk1("ct_capture", a_rxv, 1'b1);
    chk8("ct_capture_data", a_rxd, 8'h5A);
    chk1("ct_dir_after", a_dir, 1'b0);
    tick(); chk1("ct_rx_end", a_rxv, 1'b0);

    // Reset asserted in the middle of a burst.
    a_tx_valid = 1'b1; a_tx_data = 8'hE1; a_txq.push_back(8'hE1);
    tick(); tick(); tick();
    chk1("mr_drive_dir", a_dir, 1'b1);
    tick(); a_tx_data = 8'hE2; rst = 1'b1;
    #1 chk1("mr_inflight_ready", a_ready, 1'b0);
    tick();
    chk1("mr_dir", a_dir, 1'b0);
    chk1("mr_rxv", a_rxv, 1'b0);
    chk1("mr_col", a_col, 1'b0);
    chk8("mr_rxd", a_rxd, 8'h00);
    tick(); rst = 1'b0; a_tx_valid = 1'b0;
    #1 chk1("mr_dir_released", a_dir, 1'b0);

    // TURN=0: collision while offering the second word.
    b_tx_valid = 1'b1; b_tx_data = 8'hB1; b_txq.push_back(8'hB1);
    #1 chk1("b_idle_dir", b_dir, 1'b0);
    tick();
    chk1("b_drive_dir", b_dir, 1'b1);
    chk1("b_drive_ready", b_ready, 1'b1);
    chk8("b_drive_bus", b_bus, 8'hB1);
    tick();
    b_tx_data = 8'hB2; b_peer = 1'b1; b_peer_dat = 8'hC3; b_colq.push_back(1);
    #1 chk1("b_col_ready", b_ready, 1'b0);
    tick(); b_peer = 1'b0; b_tx_valid = 1'b0;
    chk1("b_col_dir", b_dir, 1'b0);
    chk1("b_col_pulse", b_col, 1'b1);
    tick();
    chk1("b_col_end", b_col, 1'b0);
    chk1("b_idle_dir2", b_dir, 1'b0);
    tick();

    chk16("a_txq_drained", 16'(a_txq.size()), 16'h0000);
    chk16("a_rxq_drained", 16'(a_rxq.size()), 16'h0000);
    chk16("a_colq_drained", 16'(a_colq.size()), 16'h0000);
    chk16("b_txq_drained", 16'(b_txq.size()), 16'h0000);
    chk16("b_colq_drained", 16'(b_colq.size()), 16'h0000);
    chk16("b_rxq_drained", 16'(b_rxq.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
